// File: rtl/accum_differencer_if.sv
// Stream bundle for accum_differencer: accumulator samples in,
// recovered addends out, valid/ready on both sides.
interface accum_differencer_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_accum;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_diff;
  logic             out_borrow;
  logic             out_first;

  modport slave (
    input  in_valid, in_accum, out_ready,
    output in_ready, out_valid, out_diff, out_borrow, out_first
  );

  modport master (
    output in_valid, in_accum, out_ready,
    input  in_ready, out_valid, out_diff, out_borrow, out_first
  );
endinterface

// File: rtl/accum_differencer.sv
// accum_differencer: recovers per-cycle addends from an accumulator stream.
// Optional accepted-sample counter enabled by defining DIFF_CNT_EN.
module accum_differencer #(
  parameter int WIDTH = 4
`ifdef DIFF_CNT_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
`ifdef DIFF_CNT_EN
  output logic [CNT_W-1:0] sample_cnt,
`endif
  accum_differencer_if.slave bus
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]       state_q;
  logic [WIDTH-1:0] prev_q;
  logic             valid_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             first_q;

  logic             ready;
  logic             accept;
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH-1:0] diff_d;
  logic             borrow_d;
  logic             first_d;

  assign ready  = !clear && (!valid_q || bus.out_ready);
  assign accept = bus.in_valid && ready;

  // Guard bit set to 1: it survives the subtract only when no borrow occurred.
  assign sub_ext = {1'b1, bus.in_accum} - {1'b0, prev_q};

  // Next result: first sample passes through, later ones are deltas.
  always_comb begin
    diff_d   = bus.in_accum;
    borrow_d = 1'b0;
    first_d  = 1'b1;
    if (state_q == S_RUN) begin
      diff_d   = sub_ext[WIDTH-1:0];
      borrow_d = ~sub_ext[WIDTH];
      first_d  = 1'b0;
    end
  end

  // Sequencing of previous sample and the registered output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_EMPTY;
      prev_q   <= '0;
      valid_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      first_q  <= 1'b0;
    end else if (clear) begin
      state_q  <= S_EMPTY;
      prev_q   <= '0;
      valid_q  <= 1'b0;
    end else if (accept) begin
      state_q  <= S_RUN;
      prev_q   <= bus.in_accum;
      valid_q  <= 1'b1;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      first_q  <= first_d;
    end else if (bus.out_ready) begin
      valid_q  <= 1'b0;
    end
  end

`ifdef DIFF_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of accepted samples since reset/clear.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (accept && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign sample_cnt = cnt_q;
`endif

  assign bus.in_ready   = ready;
  assign bus.out_valid  = valid_q;
  assign bus.out_diff   = diff_q;
  assign bus.out_borrow = borrow_q;
  assign bus.out_first  = first_q;

endmodule
